// File: rtl/class_hv_accum.sv
// Per-class hypervector training accumulator with saturating counters,
// a one-class-per-cycle clear sweep, and a registered thresholded readout.
module class_hv_accum #(
  parameter int DIM    = 16,
  parameter int NCLASS = 26,
  parameter int CW     = 8,
  parameter int CLSW   = 5
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CLSW-1:0] in_class,
  input  logic [DIM-1:0]  in_hv,
  input  logic            clr,
  input  logic            thr_mode,
  input  logic [CW-1:0]   thr,
  input  logic            rd_req,
  input  logic [CLSW-1:0] rd_class,
  output logic            rd_valid,
  output logic [DIM-1:0]  rd_hv,
  output logic            err_class,
  output logic            busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CLSW:0] NCL  = (CLSW+1)'(NCLASS);

  logic [0:0]      state;
  logic [CLSW-1:0] clr_idx;

  logic [CW-1:0] cnt  [NCLASS][DIM];
  logic [CW-1:0] scnt [NCLASS];

  logic hs;
  logic in_ok;
  logic rd_ok;
  logic wr;
  logic sweep_end;

  logic [NCLASS-1:0] clr_hit;
  logic [NCLASS-1:0] wr_hit;

  logic [CW-1:0] sel   [DIM];
  logic [CW-1:0] sel_s;
  logic [CW:0]   t;
  logic [DIM-1:0] hv_nxt;

  assign in_ready  = (state == S_IDLE) && !clr;
  assign busy      = (state == S_CLEAR);
  assign hs        = in_valid && in_ready;
  assign in_ok     = {1'b0, in_class} < NCL;
  assign rd_ok     = {1'b0, rd_class} < NCL;
  assign wr        = hs && in_ok;
  assign sweep_end = {1'b0, clr_idx} == (NCL - 1'b1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      clr_idx <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (clr) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
          end
        end
        (state == S_CLEAR): begin
          if (sweep_end) begin
            state   <= S_IDLE;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    clr_hit = '0;
    wr_hit  = '0;
    for (int c = 0; c < NCLASS; c++) begin
      clr_hit[c] = busy && (clr_idx == CLSW'(c));
      wr_hit[c]  = wr && (in_class == CLSW'(c));
    end
  end

  // Clear has priority, though a write can never coincide with a sweep.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int c = 0; c < NCLASS; c++) begin
        scnt[c] <= '0;
        for (int d = 0; d < DIM; d++) begin
          cnt[c][d] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NCLASS; c++) begin
        if (clr_hit[c]) begin
          scnt[c] <= '0;
        end else if (wr_hit[c] && scnt[c] != CMAX) begin
          scnt[c] <= scnt[c] + 1'b1;
        end
        for (int d = 0; d < DIM; d++) begin
          if (clr_hit[c]) begin
            cnt[c][d] <= '0;
          end else if (wr_hit[c] && in_hv[d] && cnt[c][d] != CMAX) begin
            cnt[c][d] <= cnt[c][d] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    sel_s = '0;
    for (int d = 0; d < DIM; d++) begin
      sel[d] = '0;
    end
    for (int c = 0; c < NCLASS; c++) begin
      if (rd_class == CLSW'(c)) begin
        sel_s = scnt[c];
        for (int d = 0; d < DIM; d++) begin
          sel[d] = cnt[c][d];
        end
      end
    end
  end

  // Majority needs strictly more than half the samples.
  always_comb begin
    if (thr_mode) begin
      t = ({1'b0, sel_s} >> 1) + (CW+1)'(1);
    end else begin
      t = {1'b0, thr};
    end
    hv_nxt = '0;
    for (int d = 0; d < DIM; d++) begin
      hv_nxt[d] = rd_ok && ({1'b0, sel[d]} >= t);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid  <= 1'b0;
      rd_hv     <= '0;
      err_class <= 1'b0;
    end else begin
      rd_valid  <= rd_req;
      err_class <= (hs && !in_ok) || (rd_req && !rd_ok);
      if (rd_req) begin
        rd_hv <= hv_nxt;
      end
    end
  end

endmodule

// File: doc/class_hv_accum.md
CLASS_HV_ACCUM -- requirements
Module: class_hv_accum

Interface
REQ-001 The block SHALL have parameter DIM, default 16, hypervector dimension count.
REQ-002 The block SHALL have parameter NCLASS, default 26, number of classes.
REQ-003 The block SHALL have parameter CW, default 8, per-dimension counter width.
REQ-004 The block SHALL have parameter CLSW, default 5, class index width, with 2^CLSW >= NCLASS.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 The block SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port in_valid, input, 1 bit: training sample present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a sample.
REQ-009 The block SHALL have port in_class, input, CLSW bits: class of the sample.
REQ-010 The block SHALL have port in_hv, input, DIM bits: binary sample hypervector.
REQ-011 The block SHALL have port clr, input, 1 bit: clear-all request pulse.
REQ-012 The block SHALL have port thr_mode, input, 1 bit: 0 = fixed threshold, 1 = majority threshold.
REQ-013 The block SHALL have port thr, input, CW bits: fixed threshold.
REQ-014 The block SHALL have port rd_req, input, 1 bit: class readout request.
REQ-015 The block SHALL have port rd_class, input, CLSW bits: class to read.
REQ-016 The block SHALL have port rd_valid, output, 1 bit: rd_hv valid.
REQ-017 The block SHALL have port rd_hv, output, DIM bits: thresholded class hypervector.
REQ-018 The block SHALL have port err_class, output, 1 bit: out-of-range class pulse.
REQ-019 The block SHALL have port busy, output, 1 bit: clear sweep in progress.

Function
REQ-020 The block SHALL hold NCLASS x DIM counters of CW bits each, plus NCLASS sample counters of CW bits each.
REQ-021 The block SHALL run an FSM with two states: IDLE and CLEAR; busy SHALL be 1 only in CLEAR.
REQ-022 in_ready SHALL be 1 in IDLE when clr = 0, and 0 otherwise.
REQ-023 On a handshake (in_valid & in_ready) with in_class < NCLASS, each counter[in_class][d] SHALL increment by in_hv[d] on that edge, and the sample counter SHALL increment by 1.
REQ-024 All counters SHALL saturate at 2^CW-1 and never wrap.
REQ-025 On a handshake with in_class >= NCLASS, no state SHALL change, and err_class SHALL pulse high for the next cycle.
REQ-026 clr = 1 in IDLE SHALL enter CLEAR; CLEAR SHALL zero one class (all its counters and its sample counter) per cycle, indices 0..NCLASS-1, then return to IDLE, for NCLASS cycles total.
REQ-027 clr while in CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-028 rd_req = 1 with rd_class < NCLASS SHALL produce rd_valid = 1 one cycle later, with rd_hv[d] = (counter[rd_class][d] >= T).
REQ-029 T SHALL be thr when thr_mode = 0, and sample_count[rd_class] >> 1 (plus 1, so strictly more than half) when thr_mode = 1; the comparison SHALL be unsigned at CW+1 bits.
REQ-030 A read in the same cycle as a write to the same class SHALL return pre-update counts.
REQ-031 A read of an out-of-range class SHALL return rd_valid = 1 with rd_hv = 0 and SHALL pulse err_class.
REQ-032 Reads SHALL be honoured during CLEAR and SHALL return current (partially cleared) contents.
REQ-033 rd_valid and err_class SHALL be single-cycle pulses; rd_hv SHALL hold its value until the next read.

Reset
REQ-034 While nrst = 0, all counters SHALL be 0, the FSM SHALL be in IDLE, and rd_valid, rd_hv, err_class and busy SHALL be 0.
REQ-035 Reset asserted mid-CLEAR SHALL abort the sweep and return to IDLE, with all counters zero.

Verification
REQ-036 DIM=16: 30 handshakes of class 0 with hv 0x00FF, thr_mode=0, thr=30, read class 0 -> rd_hv = 0x00FF one cycle after rd_req.
REQ-037 CW=8: 300 handshakes of class 2 with hv 0xFFFF -> all counters 255 (saturated), read with thr=255 -> 0xFFFF.
REQ-038 thr_mode=1: class 1 gets 3x 0x000F and 2x 0x00F0 -> T=3, rd_hv = 0x000F.
REQ-039 in_class=26 with NCLASS=26 -> err_class pulses, counters unchanged, and a read of class 26 returns 0.
REQ-040 clr pulse -> busy high for exactly 26 cycles, in_ready low throughout, and all reads afterwards return 0.
REQ-041 nrst asserted on cycle 10 of CLEAR -> busy drops immediately and in_ready = 1 after release.
